// File: rtl/mc_control_unit.sv
// mc_control_unit
//   Main sequencing FSM for the multi-cycle processor datapath. Walks each
//   instruction through IF/ID/EX/MEM/WB, drives every datapath select and
//   write enable, stalls on mem_ready, counts retired instructions and keeps
//   a sticky illegal-opcode flag.
//
//   Ports:
//     clk, reset         clock, synchronous active-low reset
//     opcode             IR[31:26], valid from ID onward
//     zero               ALU zero flag (BEQ in EX)
//     mem_ready          memory access completes this cycle
//     state              current FSM state (IF=0 ID=1 EX=2 MEM=3 WB=4)
//     pcWrite/pc_src     PC load enable and source select
//     irWrite            IR load enable
//     aluSrc1/aluSrc2    ALU operand selects, aluOp ALU function
//     ext_op             immediate extension (1 = sign)
//     regWr1/regWr2      GPR / SP write enables, regSrc destination field
//     memSrc1/memSrc2    memory address / write-data selects
//     memRd/memWr        memory requests, wbData writeback select
//     illegal            sticky illegal-opcode flag
//     instr_count        retired-instruction counter (wraps)
//
//   Handshake: a memory request (memRd/memWr) is held asserted while the FSM
//   waits; the access completes in the cycle mem_ready=1, and only in that
//   cycle do the dependent write enables fire and the FSM advance.
module mc_control_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [2:0]       state,
    output logic             pcWrite,
    output logic [1:0]       pc_src,
    output logic             irWrite,
    output logic [1:0]       aluSrc1,
    output logic [1:0]       aluSrc2,
    output logic [1:0]       aluOp,
    output logic             ext_op,
    output logic             regWr1,
    output logic             regWr2,
    output logic             regSrc,
    output logic             memSrc1,
    output logic             memSrc2,
    output logic             memRd,
    output logic             memWr,
    output logic             wbData,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [5:0] OP_AND  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_ANDI = 6'h03;
    localparam logic [5:0] OP_ADDI = 6'h04;
    localparam logic [5:0] OP_LW   = 6'h05;
    localparam logic [5:0] OP_SW   = 6'h06;
    localparam logic [5:0] OP_BEQ  = 6'h07;
    localparam logic [5:0] OP_J    = 6'h08;
    localparam logic [5:0] OP_CALL = 6'h09;
    localparam logic [5:0] OP_RET  = 6'h0A;

    state_t           state_q, state_d;
    logic [5:0]       op_q;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q;
    logic             retire;
    logic             set_illegal;
    logic [5:0]       cur_op;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IF;
            op_q      <= 6'h00;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_ID)
                op_q <= opcode;
            if (set_illegal)
                illegal_q <= 1'b1;
            if (retire)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // op_q is only loaded at the end of ID, so ID itself decodes the live opcode.
    assign cur_op = (state_q == S_ID) ? opcode : op_q;

    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        set_illegal = 1'b0;
        pcWrite     = 1'b0;
        pc_src      = 2'b00;
        irWrite     = 1'b0;
        aluSrc1     = 2'b00;
        aluSrc2     = 2'b00;
        aluOp       = 2'b00;
        ext_op      = (cur_op != OP_ANDI);
        regWr1      = 1'b0;
        regWr2      = 1'b0;
        regSrc      = 1'b0;
        memSrc1     = 1'b0;
        memSrc2     = 1'b0;
        memRd       = 1'b0;
        memWr       = 1'b0;
        wbData      = 1'b0;
        state       = state_q;
        illegal     = illegal_q;
        instr_count = cnt_q;

        case (state_q)
            S_IF: begin
                // Fetch at PC while the ALU forms PC+1.
                memRd   = 1'b1;
                aluSrc2 = 2'b10;
                aluOp   = 2'b01;
                if (mem_ready) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                case (opcode)
                    OP_J: begin
                        pcWrite = 1'b1;
                        pc_src  = 2'b10;
                        retire  = 1'b1;
                        state_d = S_IF;
                    end
                    OP_CALL: state_d = S_MEM;
                    OP_AND, OP_ADD, OP_SUB, OP_ANDI, OP_ADDI,
                    OP_LW, OP_SW, OP_BEQ, OP_RET: state_d = S_EX;
                    default: begin
                        set_illegal = 1'b1;
                        state_d     = S_IF;
                    end
                endcase
            end
            S_EX: begin
                aluSrc1 = 2'b01;
                case (op_q)
                    OP_AND:  begin aluOp = 2'b00; state_d = S_WB; end
                    OP_ADD:  begin aluOp = 2'b01; state_d = S_WB; end
                    OP_SUB:  begin aluOp = 2'b10; state_d = S_WB; end
                    OP_ANDI: begin aluSrc2 = 2'b01; aluOp = 2'b00; state_d = S_WB; end
                    OP_ADDI: begin aluSrc2 = 2'b01; aluOp = 2'b01; state_d = S_WB; end
                    OP_LW, OP_SW: begin
                        aluSrc2 = 2'b01;
                        aluOp   = 2'b01;
                        state_d = S_MEM;
                    end
                    OP_BEQ: begin
                        aluOp   = 2'b10;
                        pcWrite = zero;
                        pc_src  = 2'b01;
                        retire  = 1'b1;
                        state_d = S_IF;
                    end
                    OP_RET: begin
                        // Pre-decrement SP so MEM reads the return address.
                        aluSrc1 = 2'b10;
                        aluSrc2 = 2'b10;
                        aluOp   = 2'b10;
                        regWr2  = 1'b1;
                        state_d = S_MEM;
                    end
                    default: begin
                        aluSrc1 = 2'b00;
                        state_d = S_IF;
                    end
                endcase
            end
            S_MEM: begin
                case (op_q)
                    OP_LW: begin
                        memRd = 1'b1;
                        if (mem_ready) state_d = S_WB;
                    end
                    OP_SW: begin
                        memWr = 1'b1;
                        if (mem_ready) begin
                            retire  = 1'b1;
                            state_d = S_IF;
                        end
                    end
                    OP_CALL: begin
                        // Push PC at SP while the ALU forms SP+1.
                        memWr   = 1'b1;
                        memSrc1 = 1'b1;
                        memSrc2 = 1'b1;
                        aluSrc1 = 2'b10;
                        aluSrc2 = 2'b10;
                        aluOp   = 2'b01;
                        if (mem_ready) begin
                            regWr2  = 1'b1;
                            pcWrite = 1'b1;
                            pc_src  = 2'b10;
                            retire  = 1'b1;
                            state_d = S_IF;
                        end
                    end
                    OP_RET: begin
                        memRd   = 1'b1;
                        memSrc1 = 1'b1;
                        if (mem_ready) begin
                            pcWrite = 1'b1;
                            pc_src  = 2'b11;
                            retire  = 1'b1;
                            state_d = S_IF;
                        end
                    end
                    default: state_d = S_IF;
                endcase
            end
            S_WB: begin
                regWr1  = 1'b1;
                regSrc  = (op_q != OP_AND) && (op_q != OP_ADD) && (op_q != OP_SUB);
                wbData  = (op_q == OP_LW);
                retire  = 1'b1;
                state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase

        // Reset overrides everything, including an in-flight memory access.
        if (!reset) begin
            retire      = 1'b0;
            set_illegal = 1'b0;
            pcWrite     = 1'b0;
            pc_src      = 2'b00;
            irWrite     = 1'b0;
            aluSrc1     = 2'b00;
            aluSrc2     = 2'b00;
            aluOp       = 2'b00;
            ext_op      = 1'b0;
            regWr1      = 1'b0;
            regWr2      = 1'b0;
            regSrc      = 1'b0;
            memSrc1     = 1'b0;
            memSrc2     = 1'b0;
            memRd       = 1'b0;
            memWr       = 1'b0;
            wbData      = 1'b0;
            state       = 3'd0;
            illegal     = 1'b0;
            instr_count = '0;
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
module tb_mc_control_unit;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic [1:0] alu_src1;
        logic [1:0] alu_src2;
        logic [1:0] alu_op;
        logic       reg_wr1;
        logic       reg_wr2;
        logic       reg_src;
        logic       mem_src1;
        logic       mem_src2;
        logic       mem_rd;
        logic       mem_wr;
        logic       wb_data;
    } ctl_t;

    typedef struct packed {
        logic             rst;
        logic [5:0]       op;
        logic             zero;
        logic             rdy;
        logic [2:0]       exp_state;
        ctl_t             exp_ctl;
        logic             exp_ext;
        logic             exp_ill;
        logic [CNT_W-1:0] exp_cnt;
    } vec_t;

    logic             clk;
    logic             reset;
    logic [5:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic [2:0]       state;
    logic             pcWrite;
    logic [1:0]       pc_src;
    logic             irWrite;
    logic [1:0]       aluSrc1;
    logic [1:0]       aluSrc2;
    logic [1:0]       aluOp;
    logic             ext_op;
    logic             regWr1;
    logic             regWr2;
    logic             regSrc;
    logic             memSrc1;
    logic             memSrc2;
    logic             memRd;
    logic             memWr;
    logic             wbData;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    int tests_run = 0;
    int tests_failed = 0;

    mc_control_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .state(state), .pcWrite(pcWrite),
        .pc_src(pc_src), .irWrite(irWrite), .aluSrc1(aluSrc1),
        .aluSrc2(aluSrc2), .aluOp(aluOp), .ext_op(ext_op),
        .regWr1(regWr1), .regWr2(regWr2), .regSrc(regSrc),
        .memSrc1(memSrc1), .memSrc2(memSrc2), .memRd(memRd),
        .memWr(memWr), .wbData(wbData), .illegal(illegal),
        .instr_count(instr_count)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- helpers ----------------
    function automatic ctl_t mk(input logic pcw, input logic [1:0] pcs, input logic irw,
                                input logic [1:0] a1, input logic [1:0] a2, input logic [1:0] op,
                                input logic rw1, input logic rw2, input logic rs,
                                input logic ms1, input logic ms2, input logic mrd,
                                input logic mwr, input logic wbd);
        ctl_t c;
        c.pc_write = pcw; c.pc_src = pcs; c.ir_write = irw;
        c.alu_src1 = a1;  c.alu_src2 = a2; c.alu_op = op;
        c.reg_wr1 = rw1;  c.reg_wr2 = rw2; c.reg_src = rs;
        c.mem_src1 = ms1; c.mem_src2 = ms2; c.mem_rd = mrd;
        c.mem_wr = mwr;   c.wb_data = wbd;
        return c;
    endfunction

    function automatic vec_t mv(input logic rst, input logic [5:0] op, input logic z,
                                input logic rdy, input logic [2:0] st, input ctl_t c,
                                input logic ext, input logic ill, input logic [CNT_W-1:0] cnt);
        vec_t v;
        v.rst = rst; v.op = op; v.zero = z; v.rdy = rdy;
        v.exp_state = st; v.exp_ctl = c; v.exp_ext = ext;
        v.exp_ill = ill; v.exp_cnt = cnt;
        return v;
    endfunction

    // ---------------- driver / checker ----------------
    task automatic step(input vec_t v, input string name);
        ctl_t act;
        reset     = v.rst;
        opcode    = v.op;
        zero      = v.zero;
        mem_ready = v.rdy;
        @(negedge clk);
        act = mk(pcWrite, pc_src, irWrite, aluSrc1, aluSrc2, aluOp, regWr1, regWr2,
                 regSrc, memSrc1, memSrc2, memRd, memWr, wbData);
        tests_run++;
        if (state !== v.exp_state || act !== v.exp_ctl || ext_op !== v.exp_ext ||
            illegal !== v.exp_ill || instr_count !== v.exp_cnt) begin
            tests_failed++;
            $display("FAIL %s: got state=%0d ctl=%05h ext=%b ill=%b cnt=%0d, want state=%0d ctl=%05h ext=%b ill=%b cnt=%0d",
                     name, state, act, ext_op, illegal, instr_count,
                     v.exp_state, v.exp_ctl, v.exp_ext, v.exp_ill, v.exp_cnt);
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- test ----------------
    ctl_t z_c, if_w, if_g, id_j, ex_and, ex_add, ex_sub, ex_andi, ex_addi;
    ctl_t ex_beq1, ex_beq0, ex_ret, mem_lw, mem_sw, mem_call_w, mem_call_g;
    ctl_t mem_ret_w, mem_ret_g, wb_r, wb_i, wb_lw;
    vec_t tbl[$];
    logic [CNT_W-1:0] exp_cnt;

    initial begin
        //                pcw pcs   irw a1     a2     op     rw1 rw2 rs ms1 ms2 rd wr wbd
        z_c        = mk(0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        if_w       = mk(0, 2'b00, 0, 2'b00, 2'b10, 2'b01, 0, 0, 0, 0, 0, 1, 0, 0);
        if_g       = mk(1, 2'b00, 1, 2'b00, 2'b10, 2'b01, 0, 0, 0, 0, 0, 1, 0, 0);
        id_j       = mk(1, 2'b10, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        ex_and     = mk(0, 2'b00, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        ex_add     = mk(0, 2'b00, 0, 2'b01, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);
        ex_sub     = mk(0, 2'b00, 0, 2'b01, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0);
        ex_andi    = mk(0, 2'b00, 0, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        ex_addi    = mk(0, 2'b00, 0, 2'b01, 2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);
        ex_beq1    = mk(1, 2'b01, 0, 2'b01, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0);
        ex_beq0    = mk(0, 2'b01, 0, 2'b01, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0);
        ex_ret     = mk(0, 2'b00, 0, 2'b10, 2'b10, 2'b10, 0, 1, 0, 0, 0, 0, 0, 0);
        mem_lw     = mk(0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0);
        mem_sw     = mk(0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0);
        mem_call_w = mk(0, 2'b00, 0, 2'b10, 2'b10, 2'b01, 0, 0, 0, 1, 1, 0, 1, 0);
        mem_call_g = mk(1, 2'b10, 0, 2'b10, 2'b10, 2'b01, 0, 1, 0, 1, 1, 0, 1, 0);
        mem_ret_w  = mk(0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 1, 0, 0);
        mem_ret_g  = mk(1, 2'b11, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 1, 0, 0);
        wb_r       = mk(0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0);
        wb_i       = mk(0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0);
        wb_lw      = mk(0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 0, 1);

        //                 rst op     z  rdy st  ctl         ext ill cnt
        // reset held for two cycles
        tbl.push_back(mv(0, 6'h00, 0, 0, 0, z_c,        0, 0, 0));
        tbl.push_back(mv(0, 6'h00, 0, 0, 0, z_c,        0, 0, 0));
        // ADD
        tbl.push_back(mv(1, 6'h01, 0, 1, 0, if_g,       1, 0, 0));
        tbl.push_back(mv(1, 6'h01, 0, 1, 1, z_c,        1, 0, 0));
        tbl.push_back(mv(1, 6'h01, 0, 1, 2, ex_add,     1, 0, 0));
        tbl.push_back(mv(1, 6'h01, 0, 1, 4, wb_r,       1, 0, 0));
        // LW: three IF stalls, two MEM stalls
        tbl.push_back(mv(1, 6'h05, 0, 0, 0, if_w,       1, 0, 1));
        tbl.push_back(mv(1, 6'h05, 0, 0, 0, if_w,       1, 0, 1));
        tbl.push_back(mv(1, 6'h05, 0, 0, 0, if_w,       1, 0, 1));
        tbl.push_back(mv(1, 6'h05, 0, 1, 0, if_g,       1, 0, 1));
        tbl.push_back(mv(1, 6'h05, 0, 0, 1, z_c,        1, 0, 1));
        tbl.push_back(mv(1, 6'h05, 0, 0, 2, ex_addi,    1, 0, 1));
        tbl.push_back(mv(1, 6'h05, 0, 0, 3, mem_lw,     1, 0, 1));
        tbl.push_back(mv(1, 6'h05, 0, 0, 3, mem_lw,     1, 0, 1));
        tbl.push_back(mv(1, 6'h05, 0, 1, 3, mem_lw,     1, 0, 1));
        tbl.push_back(mv(1, 6'h05, 0, 1, 4, wb_lw,      1, 0, 1));
        // BEQ taken, BEQ not taken
        tbl.push_back(mv(1, 6'h07, 1, 1, 0, if_g,       1, 0, 2));
        tbl.push_back(mv(1, 6'h07, 1, 1, 1, z_c,        1, 0, 2));
        tbl.push_back(mv(1, 6'h07, 1, 1, 2, ex_beq1,    1, 0, 2));
        tbl.push_back(mv(1, 6'h07, 0, 1, 0, if_g,       1, 0, 3));
        tbl.push_back(mv(1, 6'h07, 0, 1, 1, z_c,        1, 0, 3));
        tbl.push_back(mv(1, 6'h07, 0, 1, 2, ex_beq0,    1, 0, 3));
        // CALL with one MEM stall
        tbl.push_back(mv(1, 6'h09, 0, 1, 0, if_g,       1, 0, 4));
        tbl.push_back(mv(1, 6'h09, 0, 1, 1, z_c,        1, 0, 4));
        tbl.push_back(mv(1, 6'h09, 0, 0, 3, mem_call_w, 1, 0, 4));
        tbl.push_back(mv(1, 6'h09, 0, 1, 3, mem_call_g, 1, 0, 4));
        // RET with one MEM stall
        tbl.push_back(mv(1, 6'h0A, 0, 1, 0, if_g,       1, 0, 5));
        tbl.push_back(mv(1, 6'h0A, 0, 1, 1, z_c,        1, 0, 5));
        tbl.push_back(mv(1, 6'h0A, 0, 1, 2, ex_ret,     1, 0, 5));
        tbl.push_back(mv(1, 6'h0A, 0, 0, 3, mem_ret_w,  1, 0, 5));
        tbl.push_back(mv(1, 6'h0A, 0, 1, 3, mem_ret_g,  1, 0, 5));
        // illegal 0x3F, then ADD with the flag still set
        tbl.push_back(mv(1, 6'h3F, 0, 1, 0, if_g,       1, 0, 6));
        tbl.push_back(mv(1, 6'h3F, 0, 1, 1, z_c,        1, 0, 6));
        tbl.push_back(mv(1, 6'h01, 0, 1, 0, if_g,       1, 1, 6));
        tbl.push_back(mv(1, 6'h01, 0, 1, 1, z_c,        1, 1, 6));
        tbl.push_back(mv(1, 6'h01, 0, 1, 2, ex_add,     1, 1, 6));
        tbl.push_back(mv(1, 6'h01, 0, 1, 4, wb_r,       1, 1, 6));
        // ANDI (zero-extend), ADDI
        tbl.push_back(mv(1, 6'h03, 0, 1, 0, if_g,       1, 1, 7));
        tbl.push_back(mv(1, 6'h03, 0, 1, 1, z_c,        0, 1, 7));
        tbl.push_back(mv(1, 6'h03, 0, 1, 2, ex_andi,    0, 1, 7));
        tbl.push_back(mv(1, 6'h03, 0, 1, 4, wb_i,       0, 1, 7));
        tbl.push_back(mv(1, 6'h04, 0, 1, 0, if_g,       0, 1, 8));
        tbl.push_back(mv(1, 6'h04, 0, 1, 1, z_c,        1, 1, 8));
        tbl.push_back(mv(1, 6'h04, 0, 1, 2, ex_addi,    1, 1, 8));
        tbl.push_back(mv(1, 6'h04, 0, 1, 4, wb_i,       1, 1, 8));
        // SUB, AND
        tbl.push_back(mv(1, 6'h02, 0, 1, 0, if_g,       1, 1, 9));
        tbl.push_back(mv(1, 6'h02, 0, 1, 1, z_c,        1, 1, 9));
        tbl.push_back(mv(1, 6'h02, 0, 1, 2, ex_sub,     1, 1, 9));
        tbl.push_back(mv(1, 6'h02, 0, 1, 4, wb_r,       1, 1, 9));
        tbl.push_back(mv(1, 6'h00, 0, 1, 0, if_g,       1, 1, 10));
        tbl.push_back(mv(1, 6'h00, 0, 1, 1, z_c,        1, 1, 10));
        tbl.push_back(mv(1, 6'h00, 0, 1, 2, ex_and,     1, 1, 10));
        tbl.push_back(mv(1, 6'h00, 0, 1, 4, wb_r,       1, 1, 10));
        // J retires in ID
        tbl.push_back(mv(1, 6'h08, 0, 1, 0, if_g,       1, 1, 11));
        tbl.push_back(mv(1, 6'h08, 0, 1, 1, id_j,       1, 1, 11));
        // SW with one MEM stall
        tbl.push_back(mv(1, 6'h06, 0, 1, 0, if_g,       1, 1, 12));
        tbl.push_back(mv(1, 6'h06, 0, 1, 1, z_c,        1, 1, 12));
        tbl.push_back(mv(1, 6'h06, 0, 1, 2, ex_addi,    1, 1, 12));
        tbl.push_back(mv(1, 6'h06, 0, 0, 3, mem_sw,     1, 1, 12));
        tbl.push_back(mv(1, 6'h06, 0, 1, 3, mem_sw,     1, 1, 12));
        // SW stalled in MEM, reset asserted in the ready cycle
        tbl.push_back(mv(1, 6'h06, 0, 1, 0, if_g,       1, 1, 13));
        tbl.push_back(mv(1, 6'h06, 0, 1, 1, z_c,        1, 1, 13));
        tbl.push_back(mv(1, 6'h06, 0, 1, 2, ex_addi,    1, 1, 13));
        tbl.push_back(mv(1, 6'h06, 0, 0, 3, mem_sw,     1, 1, 13));
        tbl.push_back(mv(0, 6'h06, 0, 1, 0, z_c,        0, 0, 0));
        tbl.push_back(mv(1, 6'h06, 0, 0, 0, if_w,       1, 0, 0));

        reset = 1'b0; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b0;
        #1;
        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i], $sformatf("vec[%0d]", i));

        // counter wrap: 17 back-to-back J instructions on a 4-bit counter
        exp_cnt = '0;
        for (int i = 0; i < 17; i++) begin
            step(mv(1, 6'h08, 0, 1, 0, if_g, 1, 0, exp_cnt), $sformatf("wrap_if[%0d]", i));
            step(mv(1, 6'h08, 0, 1, 1, id_j, 1, 0, exp_cnt), $sformatf("wrap_id[%0d]", i));
            exp_cnt = exp_cnt + 1'b1;
        end
        step(mv(1, 6'h01, 0, 0, 0, if_w, 1, 0, 4'd1), "wrap_after");

        // illegal opcode in ID while reset is asserted is ignored
        step(mv(1, 6'h3F, 0, 1, 0, if_g, 1, 0, 4'd1), "rst_ill_if");
        step(mv(0, 6'h3F, 0, 1, 0, z_c,  0, 0, 4'd0), "rst_ill_id");
        step(mv(1, 6'h09, 0, 1, 0, if_g, 1, 0, 4'd0), "rst_ill_after");

        // CALL stalled in MEM, reset in the ready cycle abandons the push
        step(mv(1, 6'h09, 0, 1, 1, z_c,        1, 0, 4'd0), "rst_call_id");
        step(mv(1, 6'h09, 0, 0, 3, mem_call_w, 1, 0, 4'd0), "rst_call_wait");
        step(mv(0, 6'h09, 0, 1, 0, z_c,        0, 0, 4'd0), "rst_call_rst");
        step(mv(1, 6'h09, 0, 0, 0, if_w,       1, 0, 4'd0), "rst_call_after");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
